fifo_uart_drain: RTL and testbench
==================================

FIFO_UART_DRAIN -- requirements
Module: fifo_uart_drain

Interface
REQ-001 Parameter MEMORY_WIDTH, default 8: width of the FIFO data word and of the serial data field.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200 baud); SHALL be >= 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 txEnable  input  1  permission to start a new frame.
REQ-006 fifoEmpty  input  1  FIFO empty flag.
REQ-007 fifoData  input  MEMORY_WIDTH  FIFO read data, registered on the edge that samples fifoRdEn high.
REQ-008 fifoRdEn  output  1  registered one-cycle FIFO pop request.
REQ-009 txd  output  1  registered serial line, idle high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frameDone  output  1  registered one-cycle pulse at the end of each stop bit.

Function
REQ-012 States SHALL be IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE -> POP when txEnable=1 and fifoEmpty=0; fifoRdEn SHALL be high exactly during the POP cycle.
REQ-014 POP -> LOAD unconditionally; LOAD SHALL capture fifoData into the shift register and go to START.
REQ-015 txd SHALL go low in the first START cycle, i.e. 3 cycles after the IDLE cycle that saw the start condition.
REQ-016 START, each DATA bit, PARITY and STOP SHALL each hold txd for exactly CLKS_PER_BIT cycles, timed by a $clog2(CLKS_PER_BIT)-bit counter cleared on every bit boundary.
REQ-017 DATA SHALL send MEMORY_WIDTH bits LSB first, using a bit index that goes to PARITY/STOP after bit MEMORY_WIDTH-1.
REQ-018 STOP SHALL drive txd=1; on its last cycle frameDone=1 for one cycle, then IDLE.
REQ-019 Frame length SHALL be (2+MEMORY_WIDTH+P)*CLKS_PER_BIT cycles, with P=1 if parity is compiled in, else 0.
REQ-020 Back-to-back frames: the next START SHALL begin 3 cycles after the STOP ends (IDLE, POP, LOAD).
REQ-021 txEnable is sampled only in IDLE; deasserting it mid-frame SHALL NOT truncate the frame.
REQ-022 fifoEmpty is sampled only in IDLE; fifoRdEn SHALL never assert while fifoEmpty=1 in IDLE.
REQ-023 At most one pop per frame; fifoRdEn SHALL NOT assert outside POP.

Reset
REQ-024 With rst=1 at a clock edge: state=IDLE, txd=1, fifoRdEn=0, busy=0, frameDone=0, counters and shift register cleared.
REQ-025 Reset mid-frame SHALL abort the frame at the next edge; the popped word is discarded and not resent.

Configuration
REQ-026 Macro FIFO_UART_DRAIN_PARITY_EN defined: PARITY state after DATA sends even parity (XOR of the data bits) for CLKS_PER_BIT cycles.
REQ-027 Macro undefined: PARITY state and logic absent; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4, MEMORY_WIDTH=8)
REQ-028 FIFO holds 0xA5, txEnable=1 -> fifoRdEn pulses 1 cycle; txd = 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; frameDone pulses once after 40 cycles.
REQ-029 Macro defined, 0xA5 -> parity bit 0 inserted before stop; with 0x07 -> parity bit 1; frame length 44 cycles.
REQ-030 fifoEmpty=1 for 100 cycles -> fifoRdEn stays 0, txd stays 1, busy stays 0.
REQ-031 FIFO holds 0x00 then 0xFF -> two frames, with exactly 3 idle-high cycles between the first stop and the second start; two fifoRdEn pulses.
REQ-032 rst=1 during data bit 3 -> next edge txd=1, busy=0; after release with fifoEmpty=1, no further txd activity.
REQ-033 txEnable=0 while the FIFO is non-empty -> no pop; txEnable dropped mid-frame -> frame completes, then no new pop.

Source files
------------

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops one word per frame from a FIFO and shifts it out LSB first on txd.
// Define FIFO_UART_DRAIN_PARITY_EN to insert an even-parity bit between the data and stop bits.

module fifo_uart_drain #(
   parameter int unsigned MEMORY_WIDTH = 8,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    txEnable,
   input  logic                    fifoEmpty,
   input  logic [MEMORY_WIDTH-1:0] fifoData,
   output logic                    fifoRdEn,
   output logic                    txd,
   output logic                    busy,
   output logic                    frameDone
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = (MEMORY_WIDTH > 1) ? $clog2(MEMORY_WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntPenult = CntW'(CLKS_PER_BIT - 2);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(MEMORY_WIDTH - 1);

`ifdef FIFO_UART_DRAIN_PARITY_EN
   typedef enum logic [2:0] {
      StIdle, StPop, StLoad, StStart, StData, StParity, StStop
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StPop, StLoad, StStart, StData, StStop
   } state_e;
`endif

   state_e                  state_q;
   logic [CntW-1:0]         cnt_q;
   logic [CntW-1:0]         cnt_nxt;
   logic [IdxW-1:0]         idx_q;
   logic [MEMORY_WIDTH-1:0] shreg_q;
   logic                    bit_end;
`ifdef FIFO_UART_DRAIN_PARITY_EN
   logic                    parity_q;
`endif

   // Bit timer wraps to zero on every bit boundary.
   assign bit_end = (cnt_q == CntLast);
   assign cnt_nxt = bit_end ? '0 : cnt_q + CntW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         txd       <= 1'b1;
         fifoRdEn  <= 1'b0;
         busy      <= 1'b0;
         frameDone <= 1'b0;
`ifdef FIFO_UART_DRAIN_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         fifoRdEn  <= 1'b0;
         frameDone <= 1'b0;
         unique case (state_q)
            StIdle: begin
               txd   <= 1'b1;
               cnt_q <= '0;
               idx_q <= '0;
               if (txEnable && !fifoEmpty) begin
                  state_q  <= StPop;
                  fifoRdEn <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            StPop: begin
               state_q <= StLoad;
            end
            // FIFO output is valid in this cycle, one edge after the pop.
            StLoad: begin
               shreg_q <= fifoData;
`ifdef FIFO_UART_DRAIN_PARITY_EN
               parity_q <= ^fifoData;
`endif
               cnt_q   <= '0;
               txd     <= 1'b0;
               state_q <= StStart;
            end
            StStart: begin
               cnt_q <= cnt_nxt;
               if (bit_end) begin
                  txd     <= shreg_q[0];
                  shreg_q <= shreg_q >> 1;
                  idx_q   <= '0;
                  state_q <= StData;
               end
            end
            StData: begin
               cnt_q <= cnt_nxt;
               if (bit_end) begin
                  if (idx_q == IdxLast) begin
`ifdef FIFO_UART_DRAIN_PARITY_EN
                     txd     <= parity_q;
                     state_q <= StParity;
`else
                     txd     <= 1'b1;
                     state_q <= StStop;
`endif
                  end else begin
                     txd     <= shreg_q[0];
                     shreg_q <= shreg_q >> 1;
                     idx_q   <= idx_q + IdxW'(1);
                  end
               end
            end
`ifdef FIFO_UART_DRAIN_PARITY_EN
            StParity: begin
               cnt_q <= cnt_nxt;
               if (bit_end) begin
                  txd     <= 1'b1;
                  state_q <= StStop;
               end
            end
`endif
            // frameDone is set one edge early so it lands on the last stop cycle.
            StStop: begin
               cnt_q <= cnt_nxt;
               if (cnt_q == CntPenult) begin
                  frameDone <= 1'b1;
               end
               if (bit_end) begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               txd     <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: FIFO model plus scoreboard of expected frames.
// Also builds with FIFO_UART_DRAIN_PARITY_EN defined; the frame model then includes parity.

module tb_fifo_uart_drain;

   localparam int W   = 8;
   localparam int CPB = 4;
`ifdef FIFO_UART_DRAIN_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB = 2 + W + P;
   localparam int FL = NB * CPB;

   logic         clk = 1'b0;
   logic         rst;
   logic         txEnable;
   logic         fifoEmpty;
   logic [W-1:0] fifoData;
   logic         fifoRdEn;
   logic         txd;
   logic         busy;
   logic         frameDone;

   int n_pass = 0;
   int n_checks = 0;
   int rd_pulses = 0;
   int bad_pops = 0;
   int done_pulses = 0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   fifo_uart_drain #(
      .MEMORY_WIDTH(W),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .txEnable (txEnable),
      .fifoEmpty(fifoEmpty),
      .fifoData (fifoData),
      .fifoRdEn (fifoRdEn),
      .txd      (txd),
      .busy     (busy),
      .frameDone(frameDone)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock; FIFO model registers read data on the edge that saw fifoRdEn high.
   task automatic tick();
      @(posedge clk);
      #1;
      if (frameDone === 1'b1) done_pulses++;
      if (fifoRdEn === 1'b1) begin
         rd_pulses++;
         if (fifoEmpty) bad_pops++;
         if (fifo_q.size() > 0) fifoData = fifo_q.pop_front();
         fifoEmpty = (fifo_q.size() == 0);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      fifoEmpty = 1'b0;
   endtask

   task automatic wait_start(output int lat);
      lat = 0;
      while (txd !== 1'b0 && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   // Receives one frame, compares the full txd and frameDone traces against the next
   // scoreboard entry, and returns the cycles waited before the start bit appeared.
   task automatic check_frame(input string tag, output int lat);
      logic [W-1:0] e;
      logic [63:0]  obs_t, exp_t, obs_d, exp_d;
      logic         b;
      int           idx;
      obs_t = '0; exp_t = '0; obs_d = '0; exp_d = '0;
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      wait_start(lat);
      for (int k = 0; k < NB; k++) begin
         if (k == 0) b = 1'b0;
         else if (k <= W) b = e[k-1];
         else if (k == W + 1 && P == 1) b = ^e;
         else b = 1'b1;
         for (int j = 0; j < CPB; j++) begin
            idx = k * CPB + j;
            obs_t[idx] = txd;
            obs_d[idx] = frameDone;
            exp_t[idx] = b;
            exp_d[idx] = (idx == FL - 1);
            if (idx != FL - 1) tick();
         end
      end
      check({tag, "_txd_trace"}, obs_t, exp_t);
      check({tag, "_done_trace"}, obs_d, exp_d);
      tick();
      check({tag, "_idle_after"}, 64'({busy, txd}), 64'(2'b01));
   endtask

   initial begin
      int lat;
      int rd0;
      int dn0;
      int viol;

      rst = 1'b1; txEnable = 1'b0; fifoEmpty = 1'b1; fifoData = '0;
      repeat (3) tick();
      check("rst_txd", 64'(txd), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_rden", 64'(fifoRdEn), 64'(0));
      check("rst_done", 64'(frameDone), 64'(0));
      rst = 1'b0;

      // Empty FIFO with permission granted: line must stay quiet.
      txEnable = 1'b1;
      viol = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (txd !== 1'b1 || busy !== 1'b0 || fifoRdEn !== 1'b0) viol++;
      end
      check("empty_quiet", 64'(viol), 64'(0));

      // Word waiting but txEnable low: no pop.
      txEnable = 1'b0;
      push_word(8'hA5);
      rd0 = rd_pulses;
      repeat (20) tick();
      check("no_en_no_pop", 64'(rd_pulses - rd0), 64'(0));
      check("no_en_busy", 64'(busy), 64'(0));

      txEnable = 1'b1;
      dn0 = done_pulses;
      check_frame("a5", lat);
      check("a5_latency", 64'(lat), 64'(3));
      check("a5_pops", 64'(rd_pulses - rd0), 64'(1));
      check("a5_done_cnt", 64'(done_pulses - dn0), 64'(1));

      // Back-to-back frames: IDLE, POP, LOAD between stop and next start.
      rd0 = rd_pulses;
      push_word(8'h00);
      push_word(8'hFF);
      check_frame("f00", lat);
      check("f00_latency", 64'(lat), 64'(3));
      check_frame("fff", lat);
      check("fff_gap", 64'(lat), 64'(3));
      repeat (20) tick();
      check("b2b_pops", 64'(rd_pulses - rd0), 64'(2));
      check("b2b_idle", 64'(busy), 64'(0));

      push_word(8'h07);
      check_frame("f07", lat);
      check("f07_latency", 64'(lat), 64'(3));

      // txEnable dropped mid-frame: frame completes, second word stays queued.
      rd0 = rd_pulses;
      push_word(8'h3C);
      push_word(8'h5A);
      lat = 0;
      while (busy !== 1'b1 && lat < 50) begin
         tick();
         lat++;
      end
      check("drop_busy_seen", 64'(busy), 64'(1));
      txEnable = 1'b0;
      check_frame("f3c", lat);
      repeat (30) tick();
      check("drop_pops", 64'(rd_pulses - rd0), 64'(1));
      check("drop_fifo_left", 64'(fifo_q.size()), 64'(1));

      // Reset during data bit 3 aborts the frame; popped word is lost.
      txEnable = 1'b1;
      wait_start(lat);
      check("rst_frame_latency", 64'(lat), 64'(3));
      repeat (CPB * 4 + 1) tick();
      check("pre_rst_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      tick();
      check("midrst_txd", 64'(txd), 64'(1));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(frameDone), 64'(0));
      rst = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      rd0 = rd_pulses;
      viol = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (txd !== 1'b1 || busy !== 1'b0) viol++;
      end
      check("post_rst_quiet", 64'(viol), 64'(0));
      check("post_rst_pops", 64'(rd_pulses - rd0), 64'(0));

      check("bad_pops", 64'(bad_pops), 64'(0));
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
